// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a TX FIFO.
// Firmware stores bytes to TXDATA (offset 0x0) and polls STATUS (offset 0x4).
// Bytes are sent as 8N1 frames on txd, LSB first.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit after
// the data bits. STATUS bit4 then reads 1.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          CLK_DIV    = 434,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_w_enable,
   input  logic        mem_r_enable,
   output logic        io_hit,
   output logic [31:0] io_rdata,
   output logic        txd
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [15:0] TICK_MAX = 16'(CLK_DIV - 1);
`ifdef UART_TX_PARITY_EN
   localparam logic        PAR_FLAG = 1'b1;
`else
   localparam logic        PAR_FLAG = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   // FIFO storage and pointers; pointers carry one extra wrap bit
   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wptr, r_rptr;
   logic        r_ovf;
   logic [31:0] r_rdata;

   // Serialiser state
   state_t      r_state, w_state_nxt;
   logic [15:0] r_timer, w_timer_nxt;
   logic [2:0]  r_bit, w_bit_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic        r_par, w_par_nxt;
   logic        r_txd, w_txd_nxt;
   logic        w_pop;

   // Bus decode and FIFO status
   logic [2:0]  w_offset;
   logic        w_push_req, w_push, w_ovf_clr;
   logic        w_empty, w_full, w_busy, w_tick;
   logic [8:0]  w_count;
   logic [7:0]  w_head;
   logic [31:0] w_status;
   logic        w_unused_wdata;

   assign io_hit     = (mem_addr[31:3] == BASE_ADDR[31:3]);
   assign w_offset   = mem_addr[2:0];
   assign w_push_req = mem_w_enable & io_hit & (w_offset == 3'h0);
   assign w_ovf_clr  = mem_w_enable & io_hit & (w_offset == 3'h4) & mem_wdata[3];

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   // Full is judged on the pre-pop state, so a store into a full FIFO is
   // dropped even if the serialiser pops in the same cycle.
   assign w_push  = w_push_req & ~w_full;
   assign w_count = 9'(r_wptr - r_rptr);
   assign w_head  = r_mem[r_rptr[AW-1:0]];
   assign w_busy  = (r_state != S_IDLE) | ~w_empty;
   assign w_tick  = (r_timer == TICK_MAX);

   assign w_status = {16'b0, w_count[7:0], 3'b0, PAR_FLAG,
                      r_ovf, w_empty, w_full, w_busy};

   assign w_unused_wdata = ^mem_wdata[31:8];

   assign io_rdata = r_rdata;
   assign txd      = r_txd;

   // FIFO storage write (no reset needed on the data array)
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= mem_wdata[7:0];
   end

   // FIFO pointers; simultaneous push and pop leaves occupancy unchanged
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Sticky overflow flag, set on a dropped store, cleared by W1C to STATUS
   always_ff @(posedge clk) begin
      if (reset)                    r_ovf <= 1'b0;
      else if (w_push_req & w_full) r_ovf <= 1'b1;
      else if (w_ovf_clr)           r_ovf <= 1'b0;
   end

   // Registered read data; holds unless a load hits the window
   always_ff @(posedge clk) begin
      if (reset)
         r_rdata <= '0;
      else if (mem_r_enable & io_hit)
         r_rdata <= (w_offset == 3'h4) ? w_status : 32'h0;
   end

   // Serialiser state register and datapath flops
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_txd   <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
         r_txd   <= w_txd_nxt;
      end
   end

   // Next state, bit timing and the txd level for the next cycle.
   // txd is computed from the next state so the flop changes together with
   // the state and the line has no combinational path.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_pop       = 1'b0;
      w_txd_nxt   = 1'b1;

      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_head;
               w_par_nxt   = ^w_head;
               w_timer_nxt = '0;
               w_bit_nxt   = '0;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_tick) begin
               w_timer_nxt = '0;
               w_state_nxt = S_DATA;
            end else begin
               w_timer_nxt = r_timer + 16'd1;
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_timer_nxt = '0;
               if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end else begin
                  w_bit_nxt   = r_bit + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
               end
            end else begin
               w_timer_nxt = r_timer + 16'd1;
            end
         end
         S_PARITY: begin
            if (w_tick) begin
               w_timer_nxt = '0;
               w_state_nxt = S_STOP;
            end else begin
               w_timer_nxt = r_timer + 16'd1;
            end
         end
         S_STOP: begin
            if (w_tick) begin
               w_timer_nxt = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + 16'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      unique case (w_state_nxt)
         S_START:  w_txd_nxt = 1'b0;
         S_DATA:   w_txd_nxt = w_shift_nxt[0];
         S_PARITY: w_txd_nxt = w_par_nxt;
         default:  w_txd_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_tx_mmio;

   localparam int          CLK_DIV = 4;
   localparam int          DEPTH   = 4;
   localparam logic [31:0] BASE    = 32'h1000_0000;
`ifdef UART_TX_PARITY_EN
   localparam bit          PAR     = 1'b1;
`else
   localparam bit          PAR     = 1'b0;
`endif
   localparam logic [31:0] ST_IDLE = 32'h0000_0004 | (32'(PAR) << 4);

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic        mem_w_enable = 1'b0;
   logic        mem_r_enable = 1'b0;
   logic        io_hit;
   logic [31:0] io_rdata;
   logic        txd;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic exp_q[$];

   uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_w_enable(mem_w_enable), .mem_r_enable(mem_r_enable),
      .io_hit(io_hit), .io_rdata(io_rdata), .txd(txd)
   );

   always #5 clk = ~clk;

   // One-cycle store; called at a falling edge, returns at the next one.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      mem_addr = a; mem_wdata = d; mem_w_enable = 1'b1;
      @(negedge clk);
      mem_w_enable = 1'b0;
   endtask

   // One-cycle load; io_rdata is sampled at the following falling edge.
   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      mem_addr = a; mem_r_enable = 1'b1;
      @(negedge clk);
      mem_r_enable = 1'b0;
      d = io_rdata;
   endtask

   // Expected txd per cycle: one idle-high cycle, then the frame.
   task automatic add_frame(input logic [7:0] b);
      exp_q.push_back(1'b1);
      repeat (CLK_DIV) exp_q.push_back(1'b0);
      for (int j = 0; j < 8; j++) repeat (CLK_DIV) exp_q.push_back(b[j]);
      if (PAR) repeat (CLK_DIV) exp_q.push_back(^b);
      repeat (CLK_DIV) exp_q.push_back(1'b1);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd);
      else pass_cnt++;
      chk_cnt++;
      if (io_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", io_rdata);
      else pass_cnt++;
      reset = 1'b0;
      bus_read(BASE + 4, rd);
      chk_cnt++;
      if (rd !== ST_IDLE) $display("FAIL reset_status: got %h want %h", rd, ST_IDLE);
      else pass_cnt++;
   endtask

   task automatic test_regmap();
      logic [31:0] rd;
      logic [31:0] hit_addr [3] = '{BASE + 7, BASE + 8, BASE - 1};
      logic        hit_exp  [3] = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         mem_addr = hit_addr[i];
         #1;
         chk_cnt++;
         if (io_hit !== hit_exp[i])
            $display("FAIL io_hit[%0d]: addr %h got %b want %b", i, hit_addr[i], io_hit, hit_exp[i]);
         else pass_cnt++;
      end
      @(negedge clk);
      bus_read(BASE + 0, rd);
      chk_cnt++;
      if (rd !== 32'h0) $display("FAIL read_txdata: got %h want 0", rd);
      else pass_cnt++;
      bus_read(BASE + 4, rd);
      bus_read(32'h2000_0004, rd);
      chk_cnt++;
      if (rd !== ST_IDLE) $display("FAIL rdata_hold: got %h want %h", rd, ST_IDLE);
      else pass_cnt++;
      bus_write(BASE + 1, 32'h55);
      bus_write(BASE + 6, 32'h66);
      bus_read(BASE + 4, rd);
      chk_cnt++;
      if (rd !== ST_IDLE) $display("FAIL odd_offset_write: status %h want %h", rd, ST_IDLE);
      else pass_cnt++;
      chk_cnt++;
      if (txd !== 1'b1) $display("FAIL odd_offset_txd: got %b want 1", txd);
      else pass_cnt++;
   endtask

   task automatic test_frame_a5();
      exp_q.delete();
      add_frame(8'hA5);
      exp_q.push_back(1'b1);
      bus_write(BASE, 32'hA5);
      for (int i = 0; i < exp_q.size(); i++) begin
         chk_cnt++;
         if (txd !== exp_q[i]) $display("FAIL frame_a5: cycle %0d got %b want %b", i, txd, exp_q[i]);
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] rd;
      bit          done = 1'b0;
      for (int i = 0; i < 6; i++) bus_write(BASE, 32'h11 + i);
      bus_read(BASE + 4, rd);
      chk_cnt++;
      if (rd !== (32'h0000_040B | (32'(PAR) << 4)))
         $display("FAIL ovf_status: got %h want %h", rd, 32'h0000_040B | (32'(PAR) << 4));
      else pass_cnt++;
      bus_write(BASE + 4, 32'h8);
      bus_read(BASE + 4, rd);
      chk_cnt++;
      if (rd !== (32'h0000_0403 | (32'(PAR) << 4)))
         $display("FAIL ovf_clear: got %h want %h", rd, 32'h0000_0403 | (32'(PAR) << 4));
      else pass_cnt++;
      for (int n = 0; n < 400 && !done; n++) begin
         bus_read(BASE + 4, rd);
         if (rd === ST_IDLE) done = 1'b1;
      end
      chk_cnt++;
      if (!done) $display("FAIL drain: status %h want %h within 400 cycles", rd, ST_IDLE);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
      exp_q.delete();
      add_frame(b0);
      add_frame(b1);
      exp_q.push_back(1'b1);
      bus_write(BASE, {24'h0, b0});
      bus_write(BASE, {24'h0, b1});
      for (int i = 1; i < exp_q.size(); i++) begin
         chk_cnt++;
         if (txd !== exp_q[i])
            $display("FAIL back_to_back %h/%h: cycle %0d got %b want %b", b0, b1, i, txd, exp_q[i]);
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int          lows = 0;
      bus_write(BASE, 32'h3C);
      bus_write(BASE, 32'hAA);
      bus_write(BASE, 32'h55);
      repeat (6) @(negedge clk);
      chk_cnt++;
      if (txd !== 1'b0) $display("FAIL mid_data_bit0: got %b want 0", txd);
      else pass_cnt++;
      reset = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (txd !== 1'b1) $display("FAIL mid_reset_txd: got %b want 1", txd);
      else pass_cnt++;
      reset = 1'b0;
      bus_read(BASE + 4, rd);
      chk_cnt++;
      if (rd !== ST_IDLE) $display("FAIL mid_reset_status: got %h want %h", rd, ST_IDLE);
      else pass_cnt++;
      repeat (100) begin
         if (txd !== 1'b1) lows++;
         @(negedge clk);
      end
      chk_cnt++;
      if (lows !== 0) $display("FAIL mid_reset_quiet: %0d low cycles want 0", lows);
      else pass_cnt++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_regmap();
      test_frame_a5();
      test_overflow();
      test_back_to_back(8'h00, 8'hC3);
`ifdef UART_TX_PARITY_EN
      test_back_to_back(8'h07, 8'h03);
`endif
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
